// File: rtl/wait_event_pkg.sv
// rtl/wait_event_pkg.sv - shared types and constants for the wait-event controller
package wait_event_pkg;

  typedef enum logic [2:0] {
    MODE_EQ     = 3'd0,
    MODE_NE     = 3'd1,
    MODE_RISE   = 3'd2,
    MODE_FALL   = 3'd3,
    MODE_CHANGE = 3'd4
  } t_wait_mode;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_TIMEOUT = 2'b01,
    STAT_ABORT   = 2'b10,
    STAT_BAD_REQ = 2'b11
  } t_wait_status;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RESP  = 2'd2
  } t_wait_state;

  localparam logic [2:0] C_WAIT_MODE_MAX = 3'd4;

endpackage

// File: rtl/wait_event_cond_eval.sv
// rtl/wait_event_cond_eval.sv - channel mux, masking and wait-mode compare
module wait_event_cond_eval
  import wait_event_pkg::*;
#(
  parameter int G_NB_CHANNELS = 8,
  parameter int G_WIDTH       = 32,
  parameter int G_SEL_WIDTH   = (G_NB_CHANNELS > 1) ? $clog2(G_NB_CHANNELS) : 1
) (
  input  logic [G_NB_CHANNELS*G_WIDTH-1:0] i_signals,
  input  logic [G_SEL_WIDTH-1:0]           i_chan,
  input  logic [2:0]                       i_mode,
  input  logic [G_WIDTH-1:0]               i_value,
  input  logic [G_WIDTH-1:0]               i_mask,
  input  logic [G_WIDTH-1:0]               i_prev,
  output logic [G_WIDTH-1:0]               o_masked,
  output logic                             o_hit
);

  logic [G_WIDTH-1:0] chan_bus;

  // Out-of-range selects read as zero; the controller never arms on them.
  always_comb begin
    chan_bus = '0;
    for (int n = 0; n < G_NB_CHANNELS; n++) begin
      if (32'(i_chan) == n) chan_bus = i_signals[n*G_WIDTH +: G_WIDTH];
    end
  end

  assign o_masked = chan_bus & i_mask;

  always_comb begin
    o_hit = 1'b0;
    case (i_mode)
      MODE_EQ:     o_hit = (o_masked == (i_value & i_mask));
      MODE_NE:     o_hit = (o_masked != (i_value & i_mask));
      MODE_RISE:   o_hit = !i_prev[0] && chan_bus[0];
      MODE_FALL:   o_hit = i_prev[0] && !chan_bus[0];
      MODE_CHANGE: o_hit = (o_masked != i_prev);
      default:     o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/wait_event_ctrl.sv
// rtl/wait_event_ctrl.sv - single-request multi-channel wait engine with timeout, abort and result handshake
module wait_event_ctrl
  import wait_event_pkg::*;
#(
  parameter int G_NB_CHANNELS   = 8,
  parameter int G_WIDTH         = 32,
  parameter int G_TIMEOUT_WIDTH = 32,
  parameter int G_SEL_WIDTH     = (G_NB_CHANNELS > 1) ? $clog2(G_NB_CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [G_NB_CHANNELS*G_WIDTH-1:0] i_signals,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic [G_SEL_WIDTH-1:0]           i_req_chan,
  input  logic [2:0]                       i_req_mode,
  input  logic [G_WIDTH-1:0]               i_req_value,
  input  logic [G_WIDTH-1:0]               i_req_mask,
  input  logic [G_TIMEOUT_WIDTH-1:0]       i_req_timeout,
  input  logic                             i_abort,
  output logic                             o_rsp_valid,
  input  logic                             i_rsp_ready,
  output logic [1:0]                       o_rsp_status,
  output logic [G_TIMEOUT_WIDTH-1:0]       o_rsp_cycles,
  output logic                             o_busy
);

  t_wait_state                      state_q, state_d;
  logic [G_NB_CHANNELS*G_WIDTH-1:0] r_sig_q, r_sig_d;
  logic [G_WIDTH-1:0]               r_prev_q, r_prev_d;
  logic [G_SEL_WIDTH-1:0]           chan_q, chan_d;
  logic [2:0]                       mode_q, mode_d;
  logic [G_WIDTH-1:0]               value_q, value_d;
  logic [G_WIDTH-1:0]               mask_q, mask_d;
  logic [G_TIMEOUT_WIDTH-1:0]       timeout_q, timeout_d;
  logic [G_TIMEOUT_WIDTH-1:0]       cnt_q, cnt_d;
  t_wait_status                     status_q, status_d;
  logic [G_TIMEOUT_WIDTH-1:0]       cycles_q, cycles_d;

  logic                             is_idle;
  logic [G_SEL_WIDTH-1:0]           eval_chan;
  logic [G_WIDTH-1:0]               eval_mask;
  logic [G_WIDTH-1:0]               eval_masked;
  logic                             eval_hit;
  logic [G_TIMEOUT_WIDTH-1:0]       cnt_next;
  logic                             bad_req;

  assign is_idle = (state_q == S_IDLE);

  // In IDLE the evaluator looks at the incoming request so r_prev can be seeded on accept.
  assign eval_chan = is_idle ? i_req_chan : chan_q;
  assign eval_mask = is_idle ? i_req_mask : mask_q;

  wait_event_cond_eval #(
    .G_NB_CHANNELS (G_NB_CHANNELS),
    .G_WIDTH       (G_WIDTH),
    .G_SEL_WIDTH   (G_SEL_WIDTH)
  ) u_cond_eval (
    .i_signals (r_sig_q),
    .i_chan    (eval_chan),
    .i_mode    (mode_q),
    .i_value   (value_q),
    .i_mask    (eval_mask),
    .i_prev    (r_prev_q),
    .o_masked  (eval_masked),
    .o_hit     (eval_hit)
  );

  assign cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign bad_req  = (32'(i_req_chan) >= G_NB_CHANNELS) || (i_req_mode > C_WAIT_MODE_MAX);

  always_comb begin
    state_d   = state_q;
    r_sig_d   = i_signals;
    r_prev_d  = r_prev_q;
    chan_d    = chan_q;
    mode_d    = mode_q;
    value_d   = value_q;
    mask_d    = mask_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    cycles_d  = cycles_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          if (bad_req) begin
            state_d  = S_RESP;
            status_d = STAT_BAD_REQ;
            cycles_d = '0;
          end else begin
            state_d   = S_ARMED;
            chan_d    = i_req_chan;
            mode_d    = i_req_mode;
            value_d   = i_req_value;
            mask_d    = i_req_mask;
            timeout_d = i_req_timeout;
            r_prev_d  = eval_masked;
            cnt_d     = '0;
          end
        end
      end
      S_ARMED: begin
        cnt_d    = cnt_next;
        r_prev_d = eval_masked;
        // Abort beats a hit, and a hit beats a timeout expiring on the same cycle.
        if (i_abort) begin
          state_d  = S_RESP;
          status_d = STAT_ABORT;
          cycles_d = cnt_next;
        end else if (eval_hit) begin
          state_d  = S_RESP;
          status_d = STAT_OK;
          cycles_d = cnt_next;
        end else if ((timeout_q != '0) && (cnt_next == timeout_q)) begin
          state_d  = S_RESP;
          status_d = STAT_TIMEOUT;
          cycles_d = cnt_next;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      r_sig_q   <= '0;
      r_prev_q  <= '0;
      chan_q    <= '0;
      mode_q    <= '0;
      value_q   <= '0;
      mask_q    <= '0;
      timeout_q <= '0;
      cnt_q     <= '0;
      status_q  <= STAT_OK;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      r_sig_q   <= r_sig_d;
      r_prev_q  <= r_prev_d;
      chan_q    <= chan_d;
      mode_q    <= mode_d;
      value_q   <= value_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      cycles_q  <= cycles_d;
    end
  end

  assign o_req_ready  = is_idle && !rst;
  assign o_rsp_valid  = (state_q == S_RESP);
  assign o_busy       = (state_q == S_ARMED) || (state_q == S_RESP);
  assign o_rsp_status = status_q;
  assign o_rsp_cycles = cycles_q;

endmodule

// File: tb/tb_wait_event_ctrl.sv
// tb/tb_wait_event_ctrl.sv - scoreboard bench for wait_event_ctrl
module tb_wait_event_ctrl;

  localparam int NCH = 6;
  localparam int W   = 32;
  localparam int TW  = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH*W-1:0] i_signals = '0;
  logic            i_req_valid = 1'b0;
  logic            o_req_ready;
  logic [2:0]      i_req_chan = '0;
  logic [2:0]      i_req_mode = '0;
  logic [W-1:0]    i_req_value = '0;
  logic [W-1:0]    i_req_mask = '0;
  logic [TW-1:0]   i_req_timeout = '0;
  logic            i_abort = 1'b0;
  logic            o_rsp_valid;
  logic            i_rsp_ready = 1'b1;
  logic [1:0]      o_rsp_status;
  logic [TW-1:0]   o_rsp_cycles;
  logic            o_busy;

  wait_event_ctrl #(
    .G_NB_CHANNELS   (NCH),
    .G_WIDTH         (W),
    .G_TIMEOUT_WIDTH (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_signals     (i_signals),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_chan    (i_req_chan),
    .i_req_mode    (i_req_mode),
    .i_req_value   (i_req_value),
    .i_req_mask    (i_req_mask),
    .i_req_timeout (i_req_timeout),
    .i_abort       (i_abort),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_status  (o_rsp_status),
    .o_rsp_cycles  (o_rsp_cycles),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic        ctl_en = 1'b0;
  logic [2:0]  ctl_exp = '0;
  string       ctl_name = "";
  logic        stab_en = 1'b0;
  logic [1:0]  stab_st = '0;
  logic [31:0] stab_cyc = '0;
  int          to_req = 0;
  int          to_seen = 0;
  string       to_name = "";

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    if (ctl_en) begin
      n_cmp++;
      if ({o_req_ready, o_busy, o_rsp_valid} !== ctl_exp) begin
        n_err++;
        $display("FAIL %s: ready/busy/valid=%b required %b", ctl_name,
                 {o_req_ready, o_busy, o_rsp_valid}, ctl_exp);
      end
    end
    if (stab_en) begin
      n_cmp++;
      if (o_rsp_status !== stab_st || o_rsp_cycles !== stab_cyc) begin
        n_err++;
        $display("FAIL %s_hold: status=%0d cycles=%0d required status=%0d cycles=%0d",
                 ctl_name, o_rsp_status, o_rsp_cycles, stab_st, stab_cyc);
      end
    end
    if (to_req != to_seen) begin
      to_seen = to_req;
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no response within budget, required one", to_name);
    end
    if (!rst && o_rsp_valid && i_rsp_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rsp: status=%0d cycles=%0d required no response",
                 o_rsp_status, o_rsp_cycles);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_rsp_status !== e.st || o_rsp_cycles !== e.cyc) begin
          n_err++;
          $display("FAIL %s: status=%0d cycles=%0d required status=%0d cycles=%0d",
                   e.name, o_rsp_status, o_rsp_cycles, e.st, e.cyc);
        end
      end
    end
  end

  task automatic set_chan(input int ch, input logic [W-1:0] v);
    i_signals[ch*W +: W] = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [1:0] st, input logic [31:0] c, input string nm);
    exp_t e;
    e.st = st; e.cyc = c; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Returns at accept edge + 1 time unit.
  task automatic send(input logic [2:0] ch, input logic [2:0] md, input logic [W-1:0] val,
                      input logic [W-1:0] msk, input logic [TW-1:0] to);
    cyc(1);
    i_req_valid = 1'b1; i_req_chan = ch; i_req_mode = md;
    i_req_value = val; i_req_mask = msk; i_req_timeout = to;
    cyc(1);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (exp_q.size() != 0) begin
      to_name = nm;
      to_req++;
      exp_q.delete();
    end
  endtask

  task automatic ctl(input logic [2:0] e, input string nm);
    ctl_exp = e; ctl_name = nm; ctl_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation stuck, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    ctl(3'b000, "reset_ctl");
    stab_st = 2'b00; stab_cyc = 32'd0; stab_en = 1'b1;
    cyc(1);
    stab_en = 1'b0;
    rst = 1'b0;
    ctl(3'b100, "post_reset_ctl");
    cyc(1);
    ctl_en = 1'b0;

    // Level hit EQ, value present at the 5th edge after accept
    set_chan(2, 32'h0);
    send(3'd2, 3'd0, 32'hCAFEDECA, 32'hFFFFFFFF, 32'd100);
    expect_rsp(2'b00, 32'd6, "level_eq");
    cyc(4);
    set_chan(2, 32'hCAFEDECA);
    wait_done(50, "level_eq");

    // Masked level already true: first ARMED cycle
    set_chan(3, 32'h12345678);
    send(3'd3, 3'd0, 32'hFFFF56FF, 32'h0000FF00, 32'd0);
    expect_rsp(2'b00, 32'd1, "level_first_cycle");
    ctl(3'b010, "armed_ctl");
    cyc(1);
    ctl_en = 1'b0;
    wait_done(10, "level_first_cycle");

    // NE with masked-out change first
    set_chan(4, 32'h0);
    send(3'd4, 3'd1, 32'h0, 32'h000000FF, 32'd0);
    expect_rsp(2'b00, 32'd5, "ne_masked");
    cyc(1);
    set_chan(4, 32'h100);
    cyc(2);
    set_chan(4, 32'h101);
    wait_done(50, "ne_masked");

    // RISE: initial high must not hit; fall at +3, rise at +7
    set_chan(0, 32'h1);
    send(3'd0, 3'd2, 32'h0, 32'hFFFFFFFF, 32'd0);
    expect_rsp(2'b00, 32'd8, "rise_edge");
    cyc(2);
    set_chan(0, 32'h0);
    cyc(4);
    set_chan(0, 32'h1);
    wait_done(50, "rise_edge");

    // FALL on chan0 at +2
    send(3'd0, 3'd3, 32'h0, 32'h1, 32'd0);
    expect_rsp(2'b00, 32'd3, "fall_edge");
    cyc(1);
    set_chan(0, 32'h0);
    wait_done(50, "fall_edge");

    // CHANGE with a masked-out change first
    set_chan(5, 32'hF0);
    send(3'd5, 3'd4, 32'h0, 32'h0000000F, 32'd0);
    expect_rsp(2'b00, 32'd6, "change");
    cyc(1);
    set_chan(5, 32'h00);
    cyc(3);
    set_chan(5, 32'h03);
    wait_done(50, "change");

    // Timeout
    set_chan(1, 32'hAAAAAAAA);
    send(3'd1, 3'd0, 32'h55555555, 32'hFFFFFFFF, 32'd10);
    expect_rsp(2'b01, 32'd10, "timeout");
    wait_done(50, "timeout");

    // Hit on the expiry cycle wins
    send(3'd1, 3'd0, 32'h55555555, 32'hFFFFFFFF, 32'd10);
    expect_rsp(2'b00, 32'd10, "hit_at_timeout");
    cyc(8);
    set_chan(1, 32'h55555555);
    wait_done(50, "hit_at_timeout");
    set_chan(1, 32'hAAAAAAAA);

    // Abort beats a simultaneous hit on ARMED cycle 4
    set_chan(2, 32'h0);
    send(3'd2, 3'd0, 32'hCAFEDECA, 32'hFFFFFFFF, 32'd0);
    expect_rsp(2'b10, 32'd4, "abort");
    cyc(2);
    set_chan(2, 32'hCAFEDECA);
    cyc(1);
    i_abort = 1'b1;
    cyc(1);
    i_abort = 1'b0;
    wait_done(50, "abort");

    // Bad channel and bad mode: response on the next cycle
    expect_rsp(2'b11, 32'd0, "bad_chan");
    send(3'd6, 3'd0, 32'h0, 32'h0, 32'd5);
    ctl(3'b011, "bad_chan_ctl");
    cyc(1);
    ctl_en = 1'b0;
    wait_done(5, "bad_chan");
    expect_rsp(2'b11, 32'd0, "bad_mode");
    send(3'd0, 3'd5, 32'h0, 32'h0, 32'd5);
    wait_done(5, "bad_mode");

    // Backpressure: result held stable for 20 cycles
    i_rsp_ready = 1'b0;
    send(3'd3, 3'd0, 32'hFFFF56FF, 32'h0000FF00, 32'd0);
    expect_rsp(2'b00, 32'd1, "backpressure");
    cyc(1);
    ctl(3'b011, "bp");
    stab_st = 2'b00; stab_cyc = 32'd1; stab_en = 1'b1;
    cyc(20);
    stab_en = 1'b0;
    ctl_en = 1'b0;
    i_rsp_ready = 1'b1;
    wait_done(5, "backpressure");
    ctl(3'b100, "post_handshake_ctl");
    cyc(1);
    ctl_en = 1'b0;

    // Reset while ARMED discards the wait
    set_chan(2, 32'h0);
    send(3'd2, 3'd0, 32'hCAFEDECA, 32'hFFFFFFFF, 32'd0);
    cyc(2);
    rst = 1'b1;
    ctl(3'b010, "rst_armed_ctl");
    cyc(1);
    ctl(3'b000, "rst_applied_ctl");
    set_chan(2, 32'hCAFEDECA);
    cyc(1);
    rst = 1'b0;
    ctl(3'b100, "rst_release_ctl");
    cyc(3);
    ctl_en = 1'b0;

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
